thor2024_commit_ctrl: RTL and testbench

THOR2024_COMMIT_CTRL -- requirements
Module: thor2024_commit_ctrl

---
 rtl/thor2024_commit_ctrl.sv | 119 +++++++++++
 tb/tb_thor2024_commit_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/thor2024_commit_ctrl.sv
// In-order dual-retire commit controller for the issue queue.
// Retires up to two entries per cycle from the head pair, and turns an
// exception at the oldest entry into a request/acknowledge handshake
// followed by a one-cycle queue flush.
module thor2024_commit_ctrl #(
    parameter int unsigned QENTRIES = 8,
    localparam int unsigned QW = $clog2(QENTRIES),
    localparam int unsigned CW = QW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [QENTRIES-1:0] iq_v,
    input  logic [QENTRIES-1:0] iq_done,
    input  logic [QENTRIES-1:0] iq_exc,
    input  logic [QW-1:0]       tail0,
    input  logic                exc_ack,
    output logic [QW-1:0]       head0,
    output logic [QW-1:0]       head1,
    output logic                commit0,
    output logic                commit1,
    output logic                exc_req,
    output logic                flush,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);

    typedef enum logic [1:0] {StRun, StExc, StFlush} state_e;

    state_e          r_state;
    logic [QW-1:0]   r_head0;
    logic            r_commit0;
    logic            r_commit1;
    logic            r_exc_req;
    logic            r_flush;
    logic [CW-1:0]   r_count;

    logic [QW-1:0]   w_head1;
    logic            w_c0;
    logic            w_c1;
    logic            w_head_exc;
    logic [QW-1:0]   w_adv;
    logic [CW-1:0]   w_pop;

    assign w_head1 = r_head0 + QW'(1);

    // Retire eligibility at the head pair; head1 may only retire alongside head0
    always_comb begin
        w_c0       = iq_v[r_head0] & iq_done[r_head0] & ~iq_exc[r_head0];
        w_c1       = w_c0 & iq_v[w_head1] & iq_done[w_head1] & ~iq_exc[w_head1];
        w_head_exc = iq_v[r_head0] & iq_done[r_head0] & iq_exc[r_head0];
        w_adv      = w_c1 ? QW'(2) : (w_c0 ? QW'(1) : '0);
    end

    // Occupancy popcount of the valid vector
    always_comb begin
        w_pop = '0;
        for (int unsigned i = 0; i < QENTRIES; i++) begin
            w_pop = w_pop + CW'(iq_v[i]);
        end
    end

    // Commit FSM with registered pulses, head pointer and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StRun;
            r_head0   <= '0;
            r_commit0 <= 1'b0;
            r_commit1 <= 1'b0;
            r_exc_req <= 1'b0;
            r_flush   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_count   <= w_pop;
            r_commit0 <= 1'b0;
            r_commit1 <= 1'b0;
            r_flush   <= 1'b0;
            case (r_state)
                StRun: begin
                    if (w_head_exc) begin
                        r_state   <= StExc;
                        r_exc_req <= 1'b1;
                    end else begin
                        r_commit0 <= w_c0;
                        r_commit1 <= w_c1;
                        r_head0   <= r_head0 + w_adv;
                    end
                end
                StExc: begin
                    if (exc_ack) begin
                        r_state   <= StFlush;
                        r_exc_req <= 1'b0;
                        r_flush   <= 1'b1;
                    end
                end
                StFlush: begin
                    // Queue is being emptied; restart retirement at the allocation point
                    r_state <= StRun;
                    r_head0 <= tail0;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    assign head0   = r_head0;
    assign head1   = w_head1;
    assign commit0 = r_commit0 & ~r_flush;
    assign commit1 = r_commit1 & ~r_flush;
    assign exc_req = r_exc_req;
    assign flush   = r_flush;
    assign count   = r_count;
    assign empty   = (r_count == '0);
    // One slot held back so a dual enqueue never overruns the queue
    assign full    = (r_count >= CW'(QENTRIES - 1));

endmodule

// File: tb/tb_thor2024_commit_ctrl.sv
// Directed bench for thor2024_commit_ctrl with QENTRIES = 8.
module tb_thor2024_commit_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] iq_v;
    logic [7:0] iq_done;
    logic [7:0] iq_exc;
    logic [2:0] tail0;
    logic       exc_ack;
    logic [2:0] head0;
    logic [2:0] head1;
    logic       commit0;
    logic       commit1;
    logic       exc_req;
    logic       flush;
    logic [3:0] count;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    thor2024_commit_ctrl #(.QENTRIES(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .iq_v    (iq_v),
        .iq_done (iq_done),
        .iq_exc  (iq_exc),
        .tail0   (tail0),
        .exc_ack (exc_ack),
        .head0   (head0),
        .head1   (head1),
        .commit0 (commit0),
        .commit1 (commit1),
        .exc_req (exc_req),
        .flush   (flush),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic [7:0] d, input logic [7:0] e);
        iq_v    = v;
        iq_done = d;
        iq_exc  = e;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(8'h00, 8'h00, 8'h00);
        tail0   = 3'd0;
        exc_ack = 1'b0;
        step();
        step();
        checks++;
        if ({head0, head1} !== {3'd0, 3'd1}) begin
            errors++;
            $display("FAIL reset_heads got %0d/%0d want 0/1", head0, head1);
        end
        checks++;
        if ({commit0, commit1, exc_req, flush} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000", {commit0, commit1, exc_req, flush});
        end
        checks++;
        if ({count, empty, full} !== {4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_occ got cnt=%0d e=%b f=%b want 0 1 0", count, empty, full);
        end
        rst = 1'b0;
    endtask

    task automatic test_dual_commit();
        drive(8'h03, 8'h03, 8'h00);
        step();
        checks++;
        if ({commit0, commit1, head0, head1} !== {1'b1, 1'b1, 3'd2, 3'd3}) begin
            errors++;
            $display("FAIL dual_commit got c=%b%b h=%0d/%0d want 11 2/3",
                     commit0, commit1, head0, head1);
        end
        drive(8'h00, 8'h00, 8'h00);
        step();
        checks++;
        if ({commit0, commit1, head0} !== {1'b0, 1'b0, 3'd2}) begin
            errors++;
            $display("FAIL dual_pulse got c=%b%b h=%0d want 00 2", commit0, commit1, head0);
        end
    endtask

    task automatic test_invalid_head();
        // Done but not valid must not retire; exc_ack in RUN has no effect
        drive(8'h00, 8'hFF, 8'h00);
        exc_ack = 1'b1;
        step();
        step();
        checks++;
        if ({commit0, head0, exc_req, flush} !== {1'b0, 3'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL invalid_head got c0=%b h=%0d x=%b f=%b want 0 2 0 0",
                     commit0, head0, exc_req, flush);
        end
        exc_ack = 1'b0;
    endtask

    task automatic test_wrap();
        drive(8'h0C, 8'h0C, 8'h00);
        step();
        drive(8'h30, 8'h30, 8'h00);
        step();
        drive(8'h40, 8'h40, 8'h00);
        step();
        checks++;
        if ({commit0, commit1, head0} !== {1'b1, 1'b0, 3'd7}) begin
            errors++;
            $display("FAIL walk_to_7 got c=%b%b h=%0d want 10 7", commit0, commit1, head0);
        end
        drive(8'h81, 8'h81, 8'h00);
        step();
        checks++;
        if ({commit0, commit1, head0, head1} !== {1'b1, 1'b1, 3'd1, 3'd2}) begin
            errors++;
            $display("FAIL wrap got c=%b%b h=%0d/%0d want 11 1/2",
                     commit0, commit1, head0, head1);
        end
        drive(8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_single_commit();
        drive(8'h02, 8'h02, 8'h00);
        step();
        drive(8'h0C, 8'h04, 8'h00);
        step();
        checks++;
        if ({commit0, commit1, head0, head1} !== {1'b1, 1'b0, 3'd3, 3'd4}) begin
            errors++;
            $display("FAIL single_commit got c=%b%b h=%0d/%0d want 10 3/4",
                     commit0, commit1, head0, head1);
        end
    endtask

    task automatic test_exception();
        drive(8'h08, 8'h08, 8'h00);
        step();
        drive(8'h10, 8'h10, 8'h10);
        step();
        checks++;
        if ({exc_req, commit0, commit1, head0} !== {1'b1, 1'b0, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL exc_enter got x=%b c=%b%b h=%0d want 1 00 4",
                     exc_req, commit0, commit1, head0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({exc_req, commit0, flush, head0} !== {1'b1, 1'b0, 1'b0, 3'd4}) begin
                errors++;
                $display("FAIL exc_hold%0d got x=%b c0=%b f=%b h=%0d want 1 0 0 4",
                         i, exc_req, commit0, flush, head0);
            end
        end
        tail0   = 3'd6;
        exc_ack = 1'b1;
        step();
        checks++;
        if ({flush, exc_req, commit0, commit1} !== 4'b1000) begin
            errors++;
            $display("FAIL flush_enter got f=%b x=%b c=%b%b want 1 0 00",
                     flush, exc_req, commit0, commit1);
        end
        exc_ack = 1'b0;
        drive(8'h00, 8'h00, 8'h00);
        step();
        checks++;
        if ({flush, exc_req, head0, head1} !== {1'b0, 1'b0, 3'd6, 3'd7}) begin
            errors++;
            $display("FAIL flush_exit got f=%b x=%b h=%0d/%0d want 0 0 6/7",
                     flush, exc_req, head0, head1);
        end
    endtask

    task automatic test_exc_behind_head();
        // head0=6 clean, head1=7 faulting: retire 6 only, then fault on 7
        drive(8'hC0, 8'hC0, 8'h80);
        step();
        checks++;
        if ({commit0, commit1, head0, exc_req} !== {1'b1, 1'b0, 3'd7, 1'b0}) begin
            errors++;
            $display("FAIL exc_behind got c=%b%b h=%0d x=%b want 10 7 0",
                     commit0, commit1, head0, exc_req);
        end
        step();
        checks++;
        if ({commit0, head0, exc_req} !== {1'b0, 3'd7, 1'b1}) begin
            errors++;
            $display("FAIL exc_next got c0=%b h=%0d x=%b want 0 7 1", commit0, head0, exc_req);
        end
    endtask

    task automatic test_reset_in_exc();
        rst     = 1'b1;
        exc_ack = 1'b1;
        step();
        checks++;
        if ({head0, head1, exc_req, flush, commit0} !== {3'd0, 3'd1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_in_exc got h=%0d/%0d x=%b f=%b c0=%b want 0/1 0 0 0",
                     head0, head1, exc_req, flush, commit0);
        end
        rst     = 1'b0;
        exc_ack = 1'b0;
        drive(8'h00, 8'h00, 8'h00);
        step();
        checks++;
        if ({flush, exc_req} !== 2'b00) begin
            errors++;
            $display("FAIL rst_in_exc_after got f=%b x=%b want 0 0", flush, exc_req);
        end
    endtask

    task automatic test_count();
        drive(8'hFF, 8'h00, 8'h00);
        step();
        checks++;
        if ({count, full, empty} !== {4'd8, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL count_ff got cnt=%0d f=%b e=%b want 8 1 0", count, full, empty);
        end
        drive(8'h7F, 8'h00, 8'h00);
        step();
        checks++;
        if ({count, full, empty} !== {4'd7, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL count_7f got cnt=%0d f=%b e=%b want 7 1 0", count, full, empty);
        end
        drive(8'h3F, 8'h00, 8'h00);
        step();
        checks++;
        if ({count, full, empty} !== {4'd6, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL count_3f got cnt=%0d f=%b e=%b want 6 0 0", count, full, empty);
        end
        drive(8'h00, 8'h00, 8'h00);
        step();
        checks++;
        if ({count, full, empty} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL count_00 got cnt=%0d f=%b e=%b want 0 0 1", count, full, empty);
        end
    endtask

    initial begin
        test_reset();
        test_dual_commit();
        test_invalid_head();
        test_wrap();
        test_single_commit();
        test_exception();
        test_exc_behind_head();
        test_reset_in_exc();
        test_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
